time_sharing_inv_fir: RTL and testbench

//  Receive-side inverse of the 3-tap time-shared FIR. Recovers the original sample stream

---
 rtl/fir_pkg.sv | 38 +++
 rtl/tsh_mult_sub.sv | 55 +++++
 rtl/time_sharing_inv_fir.sv | 129 ++++++++++++
 tb/tb_time_sharing_inv_fir.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-shared FIR and its receive-side inverse:
// sample/coefficient widths, the four-state sequencing enum and the
// accumulator-to-sample saturation helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DW_IN  = 16;            // filtered sample width
    localparam int CW     = 8;             // coefficient width
    localparam int DW_OUT = 8;             // recovered sample width
    localparam int PROD_W = CW + DW_OUT;   // full signed product width
    localparam int ACC_W  = 18;            // holds DW_IN sample minus two products

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_B = 2'd1,
        MUL_C = 2'd2,
        SAT   = 2'd3
    } state_t;

    // Clamp a signed accumulator value into the signed DW_OUT range.
    function automatic logic signed [DW_OUT-1:0] sat_to_w(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-DW_OUT+1){1'b0}}, {(DW_OUT-1){1'b1}}};
        min_v = {{(ACC_W-DW_OUT+1){1'b1}}, {(DW_OUT-1){1'b0}}};
        if (v > max_v) begin
            return {1'b0, {(DW_OUT-1){1'b1}}};
        end else if (v < min_v) begin
            return {1'b1, {(DW_OUT-1){1'b0}}};
        end else begin
            return v[DW_OUT-1:0];
        end
    endfunction

endpackage

// File: rtl/tsh_mult_sub.sv
// ---------------------------------------------------------------------------
// tsh_mult_sub
// Shared multiply-subtract datapath: one registered coefficient operand, one
// registered data operand and a signed accumulator that is either loaded
// with a sign-extended sample or decremented by the operand product.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears everything)
//   load         acc <= sext(load_val)
//   load_val     DW_IN signed sample
//   mac          acc <= acc - mcoef*mdat (ignored when load is high)
//   op_load      capture op_coef/op_dat into the operand registers
//   op_coef      CW signed coefficient
//   op_dat       DW_OUT signed data operand
//   acc          ACC_W signed accumulator
// ---------------------------------------------------------------------------
module tsh_mult_sub
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [DW_IN-1:0]  load_val,
    input  logic                     mac,
    input  logic                     op_load,
    input  logic signed [CW-1:0]     op_coef,
    input  logic signed [DW_OUT-1:0] op_dat,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [CW-1:0]     mcoef;
    logic signed [DW_OUT-1:0] mdat;
    logic signed [PROD_W-1:0] prod;

    // A CW x DW_OUT signed product always fits in PROD_W bits.
    assign prod = mcoef * mdat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcoef <= '0;
            mdat  <= '0;
            acc   <= '0;
        end else begin
            if (op_load) begin
                mcoef <= op_coef;
                mdat  <= op_dat;
            end
            if (load) begin
                acc <= {{(ACC_W-DW_IN){load_val[DW_IN-1]}}, load_val};
            end else if (mac) begin
                acc <= acc - {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end
        end
    end

endmodule

// File: rtl/time_sharing_inv_fir.sv
// ---------------------------------------------------------------------------
// time_sharing_inv_fir
// Receive-side inverse of the 3-tap time-shared FIR (monic, A = 1):
//   y[n] = sat(x[n] - B*y[n-1] - C*y[n-2])
// One shared multiplier, four cycles per sample, valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   din/din_valid/din_ready     filtered sample input handshake
//   coeffB, coeffC        feedback taps, sampled when a sample is accepted
//   dout/dout_valid/dout_ready  recovered sample output handshake
// ---------------------------------------------------------------------------
module time_sharing_inv_fir
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DW_IN-1:0]  din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic signed [CW-1:0]     coeffB,
    input  logic signed [CW-1:0]     coeffC,
    output logic signed [DW_OUT-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready
);

    state_t                   state;
    state_t                   state_next;
    logic signed [CW-1:0]     reg_c;
    logic signed [DW_OUT-1:0] y1;
    logic signed [DW_OUT-1:0] y2;
    logic signed [DW_OUT-1:0] y_sat;
    logic signed [ACC_W-1:0]  acc;
    logic                     accept;
    logic                     load;
    logic                     mac;
    logic                     op_load;
    logic signed [CW-1:0]     op_coef;
    logic signed [DW_OUT-1:0] op_dat;

    // A new sample is only taken when the previous result is gone or leaves
    // on this same edge, so an unread result is never overwritten.
    assign din_ready = (state == IDLE) && (!dout_valid || dout_ready);
    assign accept    = din_valid && din_ready;
    assign y_sat     = sat_to_w(acc);

    tsh_mult_sub u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (din),
        .mac      (mac),
        .op_load  (op_load),
        .op_coef  (op_coef),
        .op_dat   (op_dat),
        .acc      (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencing: IDLE loads the sample and the B operands, MUL_B subtracts
    // B*y1 while staging C*y2, MUL_C subtracts C*y2, SAT publishes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        mac        = 1'b0;
        op_load    = 1'b0;
        op_coef    = coeffB;
        op_dat     = y1;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    op_load    = 1'b1;
                    state_next = MUL_B;
                end
            end
            MUL_B: begin
                mac        = 1'b1;
                op_load    = 1'b1;
                op_coef    = reg_c;
                op_dat     = y2;
                state_next = MUL_C;
            end
            MUL_C: begin
                mac        = 1'b1;
                state_next = SAT;
            end
            SAT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register and feedback history. History holds the saturated
    // value, i.e. exactly what was emitted downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            y1         <= '0;
            y2         <= '0;
            reg_c      <= '0;
        end else begin
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (accept) begin
                reg_c <= coeffC;
            end
            if (state == SAT) begin
                dout       <= y_sat;
                dout_valid <= 1'b1;
                y2         <= y1;
                y1         <= y_sat;
            end
        end
    end

endmodule

// File: tb/tb_time_sharing_inv_fir.sv
// ---------------------------------------------------------------------------
// tb_time_sharing_inv_fir
// Self-checking bench for time_sharing_inv_fir: directed scenarios plus a
// randomized run, all compared against a plain-arithmetic reference of
// y[n] = sat(x[n] - B*y[n-1] - C*y[n-2]).
// ---------------------------------------------------------------------------
module tb_time_sharing_inv_fir;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [15:0] din;
    logic              din_valid;
    logic              din_ready;
    logic signed [7:0] coeffB;
    logic signed [7:0] coeffC;
    logic signed [7:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    int total = 0;
    int bad   = 0;

    // Reference history (what the inverse filter has emitted so far).
    int my1 = 0;
    int my2 = 0;

    always #5 clk = ~clk;

    time_sharing_inv_fir dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .coeffB     (coeffB),
        .coeffC     (coeffC),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    // Reference model: one recovered sample from the recurrence.
    function automatic int ref_step(input int x, input int b, input int c);
        int a;
        a = x - b * my1 - c * my2;
        if (a > 127) a = 127;
        else if (a < -128) a = -128;
        my2 = my1;
        my1 = a;
        return a;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        my1   = 0;
        my2   = 0;
    endtask

    // Offer one sample, wait for the result; reports edges from accept to
    // dout_valid and the value. Optionally scrambles the taps after accept.
    task automatic send(input int d, input int b, input int c, input bit scramble,
                        output int lat, output int val, output bit tmo);
        int n;
        tmo = 1'b0;
        lat = 0;
        val = 0;
        din       = 16'(d);
        coeffB    = 8'(b);
        coeffC    = 8'(c);
        din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!din_ready) begin
            tmo       = 1'b1;
            din_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = 16'($urandom);
        if (scramble) begin
            coeffB = 8'($urandom);
            coeffC = 8'($urandom);
        end
        while (!dout_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!dout_valid) tmo = 1'b1;
        val = int'(dout);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        din_valid  = 1'b1;
        din        = 16'sd77;
        coeffB     = '0;
        coeffC     = '0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_dout_valid: got %b expected 0", dout_valid);
        end
        total++;
        if (dout !== 8'sd0) begin
            bad++; $display("[TB] FAIL reset_dout: got %0d expected 0", dout);
        end
        total++;
        if (din_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_din_ready: got %b expected 1", din_ready);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        rst_n      = 1'b1;
        my1 = 0;
        my2 = 0;
    endtask

    task automatic test_passthrough();
        int xs[3]  = '{5, -7, 100};
        int exp[3] = '{5, -7, 100};
        int lat, val;
        bit tmo;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], 0, 0, 1'b0, lat, val, tmo);
            void'(ref_step(xs[i], 0, 0));
            total++;
            if (tmo || val != exp[i]) begin
                bad++; $display("[TB] FAIL passthrough[%0d]: got %0d expected %0d (timeout=%0b)", i, val, exp[i], tmo);
            end
            total++;
            if (lat != 3) begin
                bad++; $display("[TB] FAIL passthrough_latency[%0d]: got %0d expected 3", i, lat);
            end
        end
    endtask

    task automatic test_inverse();
        int xs[3]  = '{1, 4, 8};
        int exp[3] = '{1, 2, 3};
        int lat, val;
        bit tmo;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], 2, 1, 1'b0, lat, val, tmo);
            void'(ref_step(xs[i], 2, 1));
            total++;
            if (tmo || val != exp[i]) begin
                bad++; $display("[TB] FAIL inverse[%0d]: got %0d expected %0d (timeout=%0b)", i, val, exp[i], tmo);
            end
        end
    endtask

    task automatic test_saturation();
        int xs[3]  = '{200, -300, 0};
        int bs[3]  = '{0, 0, 1};
        int exp[3] = '{127, -128, 127};
        int lat, val;
        bit tmo;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], bs[i], 0, 1'b0, lat, val, tmo);
            void'(ref_step(xs[i], bs[i], 0));
            total++;
            if (tmo || val != exp[i]) begin
                bad++; $display("[TB] FAIL saturation[%0d]: got %0d expected %0d (timeout=%0b)", i, val, exp[i], tmo);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp1, exp2, lat, errs;
        do_reset();
        dout_ready = 1'b0;
        din        = 16'sd10;
        coeffB     = 8'sd1;
        coeffC     = 8'sd0;
        din_valid  = 1'b1;
        @(posedge clk); #1;
        exp1 = ref_step(10, 1, 0);
        din = 16'sd50;
        lat = 0;
        while (!dout_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (!dout_valid || int'(dout) != exp1) begin
            bad++; $display("[TB] FAIL bp_first: got %0d expected %0d (valid=%b)", dout, exp1, dout_valid);
        end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (dout_valid !== 1'b1 || int'(dout) != exp1 || din_ready !== 1'b0) begin
                bad++; errs++;
                $display("[TB] FAIL bp_hold[%0d]: got dout=%0d valid=%b din_ready=%b expected dout=%0d valid=1 din_ready=0",
                         i, dout, dout_valid, din_ready, exp1);
            end
        end
        dout_ready = 1'b1;
        #1;
        total++;
        if (din_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_release_ready: got %b expected 1", din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        exp2 = ref_step(50, 1, 0);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_retire: got valid=%b expected 0", dout_valid);
        end
        lat = 0;
        while (!dout_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat != 3 || int'(dout) != exp2) begin
            bad++; $display("[TB] FAIL bp_second: got dout=%0d latency=%0d expected dout=%0d latency=3", dout, lat, exp2);
        end
    endtask

    task automatic test_coef_change();
        int xs[3] = '{20, 30, 5};
        int bs[3] = '{0, 2, 1};
        int cs[3] = '{0, 1, -1};
        int exp, lat, val;
        bit tmo;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], bs[i], cs[i], 1'b1, lat, val, tmo);
            exp = ref_step(xs[i], bs[i], cs[i]);
            total++;
            if (tmo || val != exp) begin
                bad++; $display("[TB] FAIL coef_change[%0d]: got %0d expected %0d (timeout=%0b)", i, val, exp, tmo);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, val, exp;
        bit tmo, seen;
        do_reset();
        send(60, 0, 0, 1'b0, lat, val, tmo);
        void'(ref_step(60, 0, 0));
        din       = 16'sd100;
        coeffB    = 8'sd1;
        coeffC    = 8'sd1;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        my1 = 0;
        my2 = 0;
        total++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL midreset_state: got valid=%b din_ready=%b expected valid=0 din_ready=1", dout_valid, din_ready);
        end
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (dout_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("[TB] FAIL midreset_no_output: got a dout_valid pulse expected none");
        end
        send(9, 3, 3, 1'b0, lat, val, tmo);
        exp = ref_step(9, 3, 3);
        total++;
        if (tmo || val != 9 || exp != 9) begin
            bad++; $display("[TB] FAIL midreset_history: got %0d expected 9 (timeout=%0b)", val, tmo);
        end
    endtask

    task automatic test_random();
        int x, b, c, exp, lat, val;
        bit tmo;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 255)) - 128;
            c = int'($urandom_range(0, 255)) - 128;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(x, b, c, i[0], lat, val, tmo);
            exp = ref_step(x, b, c);
            total++;
            if (tmo || val != exp || lat != 3) begin
                bad++; $display("[TB] FAIL random[%0d]: got %0d latency %0d expected %0d latency 3 (x=%0d b=%0d c=%0d)",
                                i, val, lat, exp, x, b, c);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        coeffB     = '0;
        coeffC     = '0;
        dout_ready = 1'b1;
        test_reset();
        test_passthrough();
        test_inverse();
        test_saturation();
        test_backpressure();
        test_coef_change();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
